// File: rtl/blue_pkg.sv
// Purpose: shared constants and encodings for the blue sprite motion block.
// Latency: n/a (package only).
// Backpressure: n/a.
package blue_pkg;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    localparam int SPRITE_W = 47;

    // blue_state[2:1] activity encodings
    localparam logic [1:0] ST_STAND = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_JUMP  = 2'b10;

    // blue_state[0] facing direction
    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    typedef enum logic {
        MS_GROUND = 1'b0,
        MS_AIR    = 1'b1
    } motion_e;

endpackage

// File: rtl/blue_motion_key_edge.sv
// Purpose: registered rising-edge detector for a level key input.
// Latency: rise asserts one clk after the first high sample of in.
// Backpressure: none; rise is a single-cycle pulse.
// Ports: clk, rst (sync active-high), in (level), rise (one-cycle pulse).
import blue_pkg::*;

module key_edge (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic rise
);

    logic prev_q, prev_d;
    logic rise_q, rise_d;

    always_comb begin
        prev_d = in;
        rise_d = in & ~prev_q;
    end

    // History resets to "seen high" so a key held through reset must be
    // released and pressed again before it counts as a new press.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/blue_motion.sv
// Purpose: per-frame run/jump motion of the blue sprite (GROUND/AIR FSM + clamped x/y).
// Latency: outputs update in the cycle after a tick; jump press needs 2 clk to become pending.
// Backpressure: none; state advances only on tick cycles, otherwise holds.
// Ports: clk, rst (sync active-high), tick, key_left/key_right/key_jump (levels)
//        -> blue_x[9:0], blue_y[8:0], blue_state[2:0] = {activity[1:0], dir}.
// Config: define BLUE_DOUBLE_JUMP_EN to allow one relaunch per airtime.
import blue_pkg::*;

module blue_motion #(
    parameter int X_MIN    = 0,
    parameter int X_MAX    = SCREEN_W - SPRITE_W,
    parameter int X_INIT   = 100,
    parameter int FLOOR_Y  = 400,
    parameter int RUN_STEP = 2,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1,
    parameter int VY_MAX   = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    output logic [9:0] blue_x,
    output logic [8:0] blue_y,
    output logic [2:0] blue_state
);

    // x uses 11-bit signed and y 10-bit signed so over/underflow is visible
    // to the clamps instead of wrapping.
    localparam logic signed [10:0] XMIN_S   = 11'(X_MIN);
    localparam logic signed [10:0] XMAX_S   = 11'(X_MAX);
    localparam logic signed [10:0] RUN_S    = 11'(RUN_STEP);
    localparam logic signed [9:0]  FLOOR_S  = 10'(FLOOR_Y);
    localparam logic signed [5:0]  GRAV_S   = 6'(GRAVITY);
    localparam logic signed [5:0]  VYMAX_S  = 6'(VY_MAX);
    localparam logic signed [5:0]  VY_LAUNCH = 6'(GRAVITY - JUMP_V);
    localparam logic [8:0]         JUMP_Y   = 9'(JUMP_V);
    localparam logic [8:0]         FLOOR_U  = 9'(FLOOR_Y);
    localparam logic [9:0]         XINIT_U  = 10'(X_INIT);

    motion_e            ms_q, ms_d;
    logic [9:0]         x_q, x_d;
    logic [8:0]         y_q, y_d;
    logic signed [5:0]  vy_q, vy_d;
    logic [1:0]         st_q, st_d;
    logic               dir_q, dir_d;
    logic               pend_q, pend_d;

    logic               jump_rise;
    logic               dj_ok;
    logic               launch, land, moved;
    logic signed [10:0] x_ext, x_dec, x_inc;
    logic signed [9:0]  y_sum;
    logic signed [5:0]  vy_inc;

    key_edge u_jump_edge (
        .clk  (clk),
        .rst  (rst),
        .in   (key_jump),
        .rise (jump_rise)
    );

`ifdef BLUE_DOUBLE_JUMP_EN
    logic dj_avail_q, dj_avail_d;
    assign dj_ok = dj_avail_q;
`else
    assign dj_ok = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            ms_q   <= MS_GROUND;
            x_q    <= XINIT_U;
            y_q    <= FLOOR_U;
            vy_q   <= '0;
            st_q   <= ST_STAND;
            dir_q  <= DIR_R;
            pend_q <= 1'b0;
        end else begin
            ms_q   <= ms_d;
            x_q    <= x_d;
            y_q    <= y_d;
            vy_q   <= vy_d;
            st_q   <= st_d;
            dir_q  <= dir_d;
            pend_q <= pend_d;
        end
    end

`ifdef BLUE_DOUBLE_JUMP_EN
    always_ff @(posedge clk) begin
        if (rst) dj_avail_q <= 1'b1;
        else     dj_avail_q <= dj_avail_d;
    end
`endif

    // Next-state: launch from ground (or relaunch in air when allowed), land on floor
    always_comb begin
        y_sum  = $signed({1'b0, y_q}) + $signed({{4{vy_q[5]}}, vy_q});
        launch = tick & pend_q & ((ms_q == MS_GROUND) | dj_ok);
        land   = tick & (ms_q == MS_AIR) & ~launch & (y_sum >= FLOOR_S);
        ms_d   = ms_q;
        if (launch)    ms_d = MS_AIR;
        else if (land) ms_d = MS_GROUND;
    end

    // Datapath: horizontal clamp, vertical integration, pending jump
    always_comb begin
        x_ext  = $signed({1'b0, x_q});
        x_dec  = x_ext - RUN_S;
        x_inc  = x_ext + RUN_S;
        vy_inc = vy_q + GRAV_S;
        x_d    = x_q;
        dir_d  = dir_q;
        y_d    = y_q;
        vy_d   = vy_q;
        st_d   = st_q;
        // A pending press lives until the next tick, used or not.
        pend_d = (pend_q & ~tick) | jump_rise;

        if (tick) begin
            if (key_left && !key_right) begin
                x_d   = (x_dec < XMIN_S) ? XMIN_S[9:0] : x_dec[9:0];
                dir_d = DIR_L;
            end else if (key_right && !key_left) begin
                x_d   = (x_inc > XMAX_S) ? XMAX_S[9:0] : x_inc[9:0];
                dir_d = DIR_R;
            end
        end

        if (launch) begin
            y_d  = y_q - JUMP_Y;
            vy_d = VY_LAUNCH;
        end else if (land) begin
            y_d  = FLOOR_U;
            vy_d = '0;
        end else if (tick && ms_q == MS_AIR) begin
            y_d  = y_sum[8:0];
            vy_d = (vy_inc > VYMAX_S) ? VYMAX_S : vy_inc;
        end

        // A clamped (blocked) move leaves x unchanged and so reports stand.
        moved = (x_d != x_q);
        if (tick) begin
            if (ms_d == MS_AIR) st_d = ST_JUMP;
            else if (moved)     st_d = ST_RUN;
            else                st_d = ST_STAND;
        end
    end

`ifdef BLUE_DOUBLE_JUMP_EN
    // Relaunch consumes the allowance; touching the floor restores it.
    always_comb begin
        dj_avail_d = dj_avail_q;
        if (launch && ms_q == MS_AIR) dj_avail_d = 1'b0;
        else if (land)                dj_avail_d = 1'b1;
    end
`endif

    // Outputs come straight from registers
    always_comb begin
        blue_x     = x_q;
        blue_y     = y_q;
        blue_state = {st_q, dir_q};
    end

endmodule

// File: tb/tb_blue_motion.sv
module tb_blue_motion;

    logic       clk = 1'b0;
    logic       rst, tick, key_left, key_right, key_jump;
    logic [9:0] blue_x;
    logic [8:0] blue_y;
    logic [2:0] blue_state;

    always #5 clk = ~clk;

    blue_motion dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .key_left   (key_left),
        .key_right  (key_right),
        .key_jump   (key_jump),
        .blue_x     (blue_x),
        .blue_y     (blue_y),
        .blue_state (blue_state)
    );

    typedef struct {
        int x;
        int y;
        int st;
    } exp_t;

    exp_t sb[$];
    int   nvec = 0;
    int   nerr = 0;

`ifdef BLUE_DOUBLE_JUMP_EN
    localparam bit DJ = 1'b1;
`else
    localparam bit DJ = 1'b0;
`endif

    // Reference model state
    int m_x, m_y, m_vy, m_dir;
    bit m_air, m_pend, m_allow;

    task automatic chk(input string tag, input int obs, input int expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_x = 100; m_y = 400; m_vy = 0; m_dir = 1;
        m_air = 0; m_pend = 0; m_allow = 1;
    endtask

    // Advance the model by one frame and queue the expected outputs.
    task automatic model_tick();
        int   nx;
        bit   moved;
        exp_t e;
        nx = m_x;
        if (key_left && !key_right) begin
            nx = (m_x - 2 < 0) ? 0 : m_x - 2;
            m_dir = 0;
        end else if (key_right && !key_left) begin
            nx = (m_x + 2 > 593) ? 593 : m_x + 2;
            m_dir = 1;
        end
        moved = (nx != m_x);
        m_x = nx;
        if (!m_air) begin
            if (m_pend) begin
                m_y = m_y - 12; m_vy = -11; m_air = 1; m_allow = 1;
            end
        end else if (DJ && m_pend && m_allow) begin
            m_y = m_y - 12; m_vy = -11; m_allow = 0;
        end else if (m_y + m_vy >= 400) begin
            m_y = 400; m_vy = 0; m_air = 0;
        end else begin
            m_y = m_y + m_vy;
            m_vy = (m_vy + 1 > 12) ? 12 : m_vy + 1;
        end
        m_pend = 0;
        e.x  = m_x;
        e.y  = m_y;
        e.st = (m_air ? 4 : (moved ? 2 : 0)) | m_dir;
        sb.push_back(e);
    endtask

    // Called at a negedge; drives one tick cycle and checks the registered result.
    task automatic do_tick();
        exp_t e;
        model_tick();
        tick = 1'b1;
        @(negedge clk);
        tick = 1'b0;
        e = sb.pop_front();
        chk("sb_x", int'(blue_x), e.x);
        chk("sb_y", int'(blue_y), e.y);
        chk("sb_state", int'(blue_state), e.st);
    endtask

    task automatic press_jump();
        key_jump = 1'b1;
        @(negedge clk);
        key_jump = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_pend = 1;
    endtask

    initial begin
        rst = 1'b1; tick = 1'b0;
        key_left = 1'b0; key_right = 1'b0; key_jump = 1'b0;
        @(negedge clk);
        tick = 1'b1;                      // ticks during reset are ignored
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; tick = 1'b0;
        model_reset();
        chk("rst_x", int'(blue_x), 100);
        chk("rst_y", int'(blue_y), 400);
        chk("rst_state", int'(blue_state), 1);

        // Idle frames
        repeat (10) do_tick();
        chk("idle_x", int'(blue_x), 100);
        repeat (3) @(negedge clk);
        chk("hold_no_tick_y", int'(blue_y), 400);

        // Run right
        key_right = 1'b1;
        repeat (3) do_tick();
        chk("run_x", int'(blue_x), 106);
        chk("run_state", int'(blue_state), 3);
        key_right = 1'b0;
        do_tick();
        chk("release_state", int'(blue_state), 1);

        // Single jump arc
        press_jump();
        for (int t = 1; t <= 25; t++) begin
            do_tick();
            if (t == 1)  chk("jump_t1_y", int'(blue_y), 388);
            if (t == 12) chk("jump_t12_y", int'(blue_y), 322);
            if (t == 24) chk("jump_t24_y", int'(blue_y), 388);
            if (t <= 24) chk("jump_air_st", int'(blue_state[2:1]), 2);
            if (t == 25) begin
                chk("jump_t25_y", int'(blue_y), 400);
                chk("jump_t25_state", int'(blue_state), 1);
            end
        end

        // Second press at tick 6, third press later in the same airtime
        press_jump();
        for (int t = 1; t <= 40; t++) begin
            if (t == 6 || t == 10) press_jump();
            do_tick();
            if (t == 6)            chk("dj_t6_y", int'(blue_y), DJ ? 338 : 343);
            if (t == 25 && !DJ)    chk("nodj_land_y", int'(blue_y), 400);
            if (t == 35 && DJ)     chk("dj_land_y", int'(blue_y), 400);
        end

        // Reset in the middle of a jump with key_jump held across it
        press_jump();
        repeat (4) do_tick();
        key_jump = 1'b1;
        rst = 1'b1; tick = 1'b1;
        @(negedge clk);
        rst = 1'b0; tick = 1'b0;
        model_reset();
        chk("midrst_y", int'(blue_y), 400);
        chk("midrst_x", int'(blue_x), 100);
        chk("midrst_state", int'(blue_state), 1);
        repeat (3) @(negedge clk);
        repeat (2) do_tick();
        chk("held_key_no_jump", int'(blue_y), 400);
        key_jump = 1'b0;
        @(negedge clk);
        press_jump();
        do_tick();
        chk("repress_jump_y", int'(blue_y), 388);
        repeat (24) do_tick();

        // Right wall, then left wall from an odd x
        key_right = 1'b1;
        repeat (247) do_tick();
        chk("right_wall_x", int'(blue_x), 593);
        do_tick();
        chk("right_blocked_state", int'(blue_state), 1);
        key_right = 1'b0; key_left = 1'b1;
        repeat (296) do_tick();
        chk("odd_x", int'(blue_x), 1);
        do_tick();
        chk("left_clamp_x", int'(blue_x), 0);
        chk("left_clamp_state", int'(blue_state), 2);
        do_tick();
        chk("left_blocked_x", int'(blue_x), 0);
        chk("left_blocked_state", int'(blue_state), 0);

        // Both keys: hold position and direction
        key_right = 1'b1;
        do_tick();
        chk("both_keys_state", int'(blue_state), 0);
        key_left = 1'b0;

        // Jump and run on the same tick
        press_jump();
        do_tick();
        chk("jump_run_x", int'(blue_x), 2);
        chk("jump_run_state", int'(blue_state), 5);
        key_right = 1'b0;
        repeat (24) do_tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/blue_motion.md
BLUE_MOTION -- requirements
Module: blue_motion

Interface
REQ-001 SHALL have parameters: X_MIN 0 (left bound, px); X_MAX 593 (right bound = 640-47); X_INIT 100 (reset x); FLOOR_Y 400 (ground y); RUN_STEP 2 (px/tick); JUMP_V 12 (launch speed); GRAVITY 1 (vy increment/tick); VY_MAX 12 (fall speed cap).
REQ-002 SHALL have ports: clk in 1 (sole clock, all logic on posedge); rst in 1 (synchronous, active-high reset).
REQ-003 SHALL have ports: tick in 1 (one-cycle frame pulse); key_left in 1; key_right in 1; key_jump in 1 (levels, synchronous to clk).
REQ-004 SHALL have ports: blue_x out 10 (sprite left edge); blue_y out 9 (sprite top edge); blue_state out 3 (bit0 1=right/0=left; bits[2:1] 00 stand, 01 run, 10 jump; 11 never driven).

Function
REQ-005 SHALL detect the key_jump rising edge every clk and set a pending-jump flag; the flag SHALL clear on the next tick cycle whether or not it is used.
REQ-006 SHALL change x, y, vy and state only in cycles with tick=1; all outputs SHALL be registered and valid the cycle after tick.
REQ-007 Horizontal, per tick: only key_left -> x=max(x-RUN_STEP,X_MIN), dir=left; only key_right -> x=min(x+RUN_STEP,X_MAX), dir=right; both or neither -> x and dir hold.
REQ-008 The internal vy SHALL be 6-bit signed; x and y arithmetic SHALL use one extra sign bit so clamping never wraps.
REQ-009 Grounded, pending jump at tick -> y=y-JUMP_V, vy=-JUMP_V+GRAVITY, enter AIR.
REQ-010 AIR, per tick: if y+vy>=FLOOR_Y -> y=FLOOR_Y, vy=0, enter GROUND; else y=y+vy, vy=min(vy+GRAVITY,VY_MAX).
REQ-011 blue_state[2:1] SHALL be 10 in AIR, else 01 when x moved this tick, else 00; run takes effect on the same tick as the move.
REQ-012 Jump and horizontal key on the same tick SHALL both apply; state shows jump.
REQ-013 A move blocked at X_MIN/X_MAX SHALL update dir but report stand (00) when grounded.
REQ-014 A tick with rst=1 SHALL be ignored; rst SHALL take priority over every other input.

Reset
REQ-015 On rst: blue_x=X_INIT, blue_y=FLOOR_Y, blue_state=001, vy=0, state GROUND, pending flag and edge history cleared; this SHALL also apply mid-jump.

Configuration
REQ-016 With BLUE_DOUBLE_JUMP_EN defined, one pending jump in AIR SHALL re-launch (same values as REQ-009) once per airtime; the allowance SHALL re-arm on landing.
REQ-017 Without BLUE_DOUBLE_JUMP_EN, pending jumps in AIR SHALL be discarded and no allowance register SHALL exist.

Structure
REQ-018 Shared package blue_pkg SHALL hold the blue_state encodings (ST_STAND, ST_RUN, ST_JUMP, DIR_L, DIR_R), SPRITE_W=47 and screen constants 640/480.
REQ-019 Sub-module key_edge (registered rising-edge detector, clk/rst/in/rise) SHALL be instantiated for key_jump; the GROUND/AIR FSM and arithmetic SHALL stay in blue_motion.

Verification
REQ-020 After rst, no keys, 10 ticks -> x=100, y=400, blue_state=001 throughout.
REQ-021 key_right held for 3 ticks -> x=106, blue_state=011; release, 1 tick -> 001.
REQ-022 Jump pulse, then ticks -> tick1 y=388, tick12 y=322, tick24 y=388, tick25 y=400 with state 000/001; state 10x on ticks 1-24.
REQ-023 x=1, key_left for 2 ticks -> x=0, then x=0, blue_state=010 then 000.
REQ-024 rst asserted at tick 5 of a jump -> next cycle y=400, x=100, state 001; key_jump held high across the reset -> no jump until released and pressed again.
REQ-025 BLUE_DOUBLE_JUMP_EN build: second pulse at tick 6 -> relaunch to y=y-12 on that tick; third pulse in the same airtime ignored; build without macro -> second pulse ignored, landing on tick 25.
